// File: rtl/half_adder.sv
// Unsigned WIDTH-bit adder without carry-in. It gives a combinational {C,S} = A + B
// and a registered copy {C_q,S_q} for pipelined consumers.
module half_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic [WIDTH-1:0] S_q,
  output logic             C_q
);

  logic [WIDTH:0] sum_d;

  // Widen both operands by one bit so that the carry falls out of the same add.
  assign sum_d = {1'b0, A} + {1'b0, B};
  assign S     = sum_d[WIDTH-1:0];
  assign C     = sum_d[WIDTH];

  // Registered stage: one cycle latency, no enable, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S_q <= '0;
      C_q <= 1'b0;
    end else begin
      S_q <= S;
      C_q <= C;
    end
  end

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder at WIDTH=1 and WIDTH=8. It uses table vectors for the
// combinational path and a queue scoreboard for the registered path.
module tb_half_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       a1, b1, s1, c1, sq1, cq1;
  logic [7:0] a8, b8, s8, sq8;
  logic       c8, cq8;

  int n_vec = 0;
  int n_err = 0;

  logic [1:0] sb1[$];
  logic [8:0] sb8[$];

  typedef struct {
    logic a;
    logic b;
    logic s;
    logic c;
  } vec1_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
  } vec8_t;

  vec1_t v1[5];
  vec8_t v8[3];

  half_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .S(s1), .C(c1), .S_q(sq1), .C_q(cq1)
  );

  half_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .S(s8), .C(c8), .S_q(sq8), .C_q(cq8)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop1(input string name);
    logic [1:0] e;
    if (sb1.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb1.pop_front();
      check(name, {14'd0, cq1, sq1}, {14'd0, e});
    end
  endtask

  task automatic pop8(input string name);
    logic [8:0] e;
    if (sb8.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb8.pop_front();
      check(name, {7'd0, cq8, sq8}, {7'd0, e});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] exp9;

    v1[0] = '{a: 1'b0, b: 1'b0, s: 1'b0, c: 1'b0};
    v1[1] = '{a: 1'b1, b: 1'b0, s: 1'b1, c: 1'b0};
    v1[2] = '{a: 1'b0, b: 1'b1, s: 1'b1, c: 1'b0};
    v1[3] = '{a: 1'b1, b: 1'b1, s: 1'b0, c: 1'b1};
    v1[4] = '{a: 1'b0, b: 1'b0, s: 1'b0, c: 1'b0};
    v8[0] = '{a: 8'hFF, b: 8'h01, s: 8'h00, c: 1'b1};
    v8[1] = '{a: 8'hFF, b: 8'hFF, s: 8'hFE, c: 1'b1};
    v8[2] = '{a: 8'h12, b: 8'h34, s: 8'h46, c: 1'b0};

    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    #7;
    check("reset_sq1", {15'd0, sq1}, 16'd0);
    check("reset_cq1", {15'd0, cq1}, 16'd0);
    check("reset_q8", {7'd0, cq8, sq8}, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // Combinational table vectors, WIDTH=1.
    for (int i = 0; i < 5; i++) begin
      a1 = v1[i].a; b1 = v1[i].b;
      #0;
      #1;
      check($sformatf("w1_vec%0d_S", i), {15'd0, s1}, {15'd0, v1[i].s});
      check($sformatf("w1_vec%0d_C", i), {15'd0, c1}, {15'd0, v1[i].c});
    end

    // Combinational table vectors, WIDTH=8.
    for (int i = 0; i < 3; i++) begin
      a8 = v8[i].a; b8 = v8[i].b;
      #1;
      check($sformatf("w8_vec%0d_S", i), {8'd0, s8}, {8'd0, v8[i].s});
      check($sformatf("w8_vec%0d_C", i), {15'd0, c8}, {15'd0, v8[i].c});
    end

    // Registered path, WIDTH=1: 1+1 and then 1+0.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; sb1.push_back(2'b10);
    @(posedge clk); #1;
    pop1("w1_reg_11");
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; sb1.push_back(2'b01);
    @(posedge clk); #1;
    pop1("w1_reg_10");

    // Asynchronous reset between edges while S_q=1.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; a8 = 8'h12; b8 = 8'h34;
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_sq1", {15'd0, sq1}, 16'd0);
    check("rst_async_cq1", {15'd0, cq1}, 16'd0);
    check("rst_async_q8", {7'd0, cq8, sq8}, 16'd0);
    check("rst_comb_w1", {14'd0, c1, s1}, 16'b10);
    check("rst_comb_w8", {7'd0, c8, s8}, 16'h046);
    @(posedge clk); #1;
    check("rst_hold_w1", {14'd0, cq1, sq1}, 16'd0);
    check("rst_hold_w8", {7'd0, cq8, sq8}, 16'd0);
    a8 = 8'hFF; b8 = 8'h01;
    #1;
    check("rst_comb_w8b", {7'd0, c8, s8}, 16'h100);
    @(negedge clk);
    rst = 1'b0;
    sb1.delete();
    sb8.delete();
    a1 = 1'b1; b1 = 1'b1; sb1.push_back(2'b10);
    a8 = 8'hFF; b8 = 8'hFF; sb8.push_back(9'h1FE);
    @(posedge clk); #1;
    pop1("post_rst_w1");
    pop8("post_rst_w8");

    // Random WIDTH=8 traffic with a one-cycle scoreboard.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a8 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(0, 255));
      exp9 = {1'b0, a8} + {1'b0, b8};
      #1;
      check("rand_comb", {7'd0, c8, s8}, {7'd0, exp9});
      sb8.push_back(exp9);
      @(posedge clk); #1;
      pop8("rand_reg");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
